// File: rtl/bp_common_pkg.sv
// Shared BlackParrot memory-network definitions: wormhole header layout and helpers.
// The header typedef is width-parameterised, so it is declared through a macro at the use site.
`ifndef BP_COMMON_PKG_SV
`define BP_COMMON_PKG_SV

`define DECLARE_BP_ME_WORMHOLE_HEADER_S(len_width_mp, y_cord_width_mp, x_cord_width_mp) \
    typedef struct packed { \
        logic [len_width_mp-1:0]    len; \
        logic [y_cord_width_mp-1:0] y_cord; \
        logic [x_cord_width_mp-1:0] x_cord; \
    } bp_me_wormhole_header_s

`define BP_ME_WORMHOLE_HEADER_WIDTH(len_width_mp, y_cord_width_mp, x_cord_width_mp) \
    ((len_width_mp) + (y_cord_width_mp) + (x_cord_width_mp))

package bp_common_pkg;

    // Width of the header length field for a given maximum flit count (at least 1 bit).
    function automatic int unsigned bp_me_wormhole_len_width(input int unsigned max_num_flit);
        return (max_num_flit > 1) ? $clog2(max_num_flit) : 1;
    endfunction

    // Length field saturated to the largest encodable flit index.
    function automatic int unsigned bp_me_wormhole_sat_len(input int unsigned len_field,
                                                           input int unsigned max_len);
        return (len_field > max_len) ? max_len : len_field;
    endfunction

endpackage

`endif

// File: rtl/bp_me_wormhole_flit_mux.sv
// Combinational flit selector: picks flit number cnt_i out of a zero-padded packet.
// Shared between the response and command network serializers.
module bp_me_wormhole_flit_mux #(
    parameter int unsigned flit_width_p = 16,
    parameter int unsigned num_flit_p   = 4,
    parameter int unsigned cnt_width_p  = 2
) (
    input  logic [num_flit_p*flit_width_p-1:0] pkt_i,
    input  logic [cnt_width_p-1:0]             cnt_i,
    output logic [flit_width_p-1:0]            flit_c
);

    // Decoded select keeps every index in range even for non power-of-2 flit counts.
    always_comb begin
        flit_c = '0;
        for (int i = 0; i < int'(num_flit_p); i++) begin
            if (cnt_i == cnt_width_p'(i)) begin
                flit_c = pkt_i[i*flit_width_p +: flit_width_p];
            end
        end
    end

endmodule

// File: rtl/bp_me_wormhole_pkt_serializer.sv
// Wormhole packet serializer: accepts one packet from an LCE/CCE encoder and streams
// length+1 flits, header first, onto a router link with valid/ready handshaking.
module bp_me_wormhole_pkt_serializer
    import bp_common_pkg::*;
#(
    parameter int unsigned x_cord_width_p = 2,
    parameter int unsigned y_cord_width_p = 1,
    parameter int unsigned max_num_flit_p = 4,
    parameter int unsigned flit_width_p   = 16,
    parameter int unsigned packet_width_p = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic [packet_width_p-1:0] packet_i,
    input  logic                      v_i,
    output logic                      ready_o,

    output logic [flit_width_p-1:0]   link_data_o,
    output logic                      link_v_o,
    input  logic                      link_ready_i,
    output logic                      link_last_o
);

    localparam int unsigned len_width_lp     = bp_me_wormhole_len_width(max_num_flit_p);
    localparam int unsigned pkt_ext_width_lp = max_num_flit_p * flit_width_p;
    localparam int unsigned max_len_lp       = max_num_flit_p - 1;
    localparam int unsigned header_width_lp  =
        `BP_ME_WORMHOLE_HEADER_WIDTH(len_width_lp, y_cord_width_p, x_cord_width_p);

    `DECLARE_BP_ME_WORMHOLE_HEADER_S(len_width_lp, y_cord_width_p, x_cord_width_p);

    typedef enum logic {
        e_ser_idle,
        e_ser_send
    } ser_state_e;

    ser_state_e                  state_r, state_n;
    logic [len_width_lp-1:0]     cnt_r, cnt_n;
    logic [len_width_lp-1:0]     len_r, len_n;
    logic [len_width_lp-1:0]     len_sat;
    logic [pkt_ext_width_lp-1:0] pkt_r, pkt_n;
    logic [pkt_ext_width_lp-1:0] pkt_in;
    logic [flit_width_p-1:0]     flit_c;
    bp_me_wormhole_header_s      hdr;

    // Packet is rebuilt from the typed header so every field goes through the struct.
    assign hdr     = packet_i[header_width_lp-1:0];
    assign pkt_in  = pkt_ext_width_lp'({packet_i[packet_width_p-1:header_width_lp], hdr});
    assign len_sat = len_width_lp'(bp_me_wormhole_sat_len(32'(hdr.len), max_len_lp));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_ser_idle;
            cnt_r   <= '0;
            len_r   <= '0;
            pkt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            len_r   <= len_n;
            pkt_r   <= pkt_n;
        end
    end

    // Next state and link outputs; a tail transfer may reload directly to avoid a bubble.
    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        len_n       = len_r;
        pkt_n       = pkt_r;
        ready_o     = 1'b0;
        link_v_o    = 1'b0;
        link_last_o = 1'b0;
        link_data_o = '0;

        unique case (state_r)
            e_ser_idle: begin
                ready_o = ~reset_i;
                if (v_i && !reset_i) begin
                    pkt_n   = pkt_in;
                    len_n   = len_sat;
                    cnt_n   = '0;
                    state_n = e_ser_send;
                end
            end
            e_ser_send: begin
                link_v_o    = 1'b1;
                link_data_o = flit_c;
                link_last_o = (cnt_r == len_r);
                if (link_ready_i) begin
                    if (cnt_r == len_r) begin
                        ready_o = 1'b1;
                        if (v_i) begin
                            pkt_n = pkt_in;
                            len_n = len_sat;
                            cnt_n = '0;
                        end else begin
                            state_n = e_ser_idle;
                        end
                    end else begin
                        cnt_n = cnt_r + len_width_lp'(1);
                    end
                end
            end
            default: state_n = e_ser_idle;
        endcase
    end

    bp_me_wormhole_flit_mux #(
        .flit_width_p (flit_width_p),
        .num_flit_p   (max_num_flit_p),
        .cnt_width_p  (len_width_lp)
    ) flit_mux (
        .pkt_i  (pkt_r),
        .cnt_i  (cnt_r),
        .flit_c (flit_c)
    );

    // Oversized length fields are clamped in hardware but flagged in simulation.
    always @(posedge clk_i) begin
        if (!reset_i && v_i && ready_o) begin
            len_in_range: assert (32'(hdr.len) <= max_len_lp);
        end
    end

endmodule

// File: tb/tb_bp_me_wormhole_pkt_serializer.sv
// Scoreboard bench for the wormhole serializer: directed cases plus random traffic.
module tb_bp_me_wormhole_pkt_serializer;

    localparam int unsigned FW = 16;
    localparam int unsigned NF = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [63:0] packet_i;
    logic        v_i;
    logic        ready_o;
    logic [15:0] link_data_o;
    logic        link_v_o;
    logic        link_ready_i;
    logic        link_last_o;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } flit_t;

    flit_t exp_q[$];
    int    pop_cyc[$];
    int    acc_cyc[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    lr_mode = 0;
    int    stall_left = 0;
    bit    stall_done = 1'b0;
    int    stall_obs = 0;
    bit    prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    bp_me_wormhole_pkt_serializer #(
        .x_cord_width_p (2),
        .y_cord_width_p (1),
        .max_num_flit_p (4),
        .flit_width_p   (16),
        .packet_width_p (64)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .packet_i     (packet_i),
        .v_i          (v_i),
        .ready_o      (ready_o),
        .link_data_o  (link_data_o),
        .link_v_o     (link_v_o),
        .link_ready_i (link_ready_i),
        .link_last_o  (link_last_o)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: length at bits [4:3], flits are 16-bit slices from the bottom up.
    function automatic void push_model(input logic [63:0] p);
        int unsigned len;
        flit_t f;
        len = int'((p >> 3) & 64'h3);
        if (len > NF - 1) len = NF - 1;
        for (int unsigned i = 0; i <= len; i++) begin
            f.data = 16'(p >> (FW * i));
            f.last = (i == len);
            exp_q.push_back(f);
        end
    endfunction

    // Link-side ready generator.
    initial begin
        link_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (lr_mode)
                1: link_ready_i = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0) begin
                        link_ready_i = 1'b0;
                        stall_left--;
                    end else if (!stall_done && link_v_o && link_data_o == 16'h2222) begin
                        link_ready_i = 1'b0;
                        stall_left = 4;
                        stall_done = 1'b1;
                    end else begin
                        link_ready_i = 1'b1;
                    end
                end
                default: link_ready_i = 1'b1;
            endcase
        end
    end

    // Monitor: compares every transferred flit against the scoreboard.
    initial begin
        flit_t f;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("hold_valid", 64'(link_v_o), 64'd1);
                chk("hold_data", 64'(link_data_o), 64'(prev_data));
            end
            if (link_v_o && link_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_flit: got %0h expected no flit (cycle %0d)", link_data_o, cyc);
                end else begin
                    f = exp_q.pop_front();
                    chk("flit_data", 64'(link_data_o), 64'(f.data));
                    chk("flit_last", 64'(link_last_o), 64'(f.last));
                    pop_cyc.push_back(cyc);
                end
            end
            prev_stall = link_v_o && !link_ready_i;
            prev_data  = link_data_o;
            if (prev_stall) stall_obs++;
        end
    end

    // Present a packet until accepted; returns just after the accepting edge.
    task automatic send(input logic [63:0] p);
        int n = 0;
        bit done = 1'b0;
        v_i = 1'b1;
        packet_i = p;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
            if (ready_o) begin
                done = 1'b1;
                push_model(p);
                acc_cyc.push_back(cyc);
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept expected accept within 2000 cycles");
        end
        @(posedge clk);
        #1;
        v_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || link_v_o) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset_i  = 1'b1;
        v_i      = 1'b0;
        packet_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_link_v", 64'(link_v_o), 64'd0);
        chk("rst_link_last", 64'(link_last_o), 64'd0);
        chk("rst_link_data", 64'(link_data_o), 64'd0);
        reset_i = 1'b0;
        #1;
        chk("post_rst_ready", 64'(ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Four-flit packet, no backpressure.
        pop_cyc.delete();
        send(64'h4444_3333_2222_001A);
        drain();
        chk("t1_count", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4) chk("t1_span", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

        // Two-flit packet.
        pop_cyc.delete();
        send(64'h4444_3333_2222_000A);
        drain();
        chk("t2_count", 64'(pop_cyc.size()), 64'd2);

        // Five-cycle stall on the second flit.
        pop_cyc.delete();
        stall_obs  = 0;
        stall_done = 1'b0;
        lr_mode    = 2;
        send(64'h4444_3333_2222_001A);
        drain();
        lr_mode = 0;
        chk("t3_count", 64'(pop_cyc.size()), 64'd4);
        chk("t3_stall_cycles", 64'(stall_obs), 64'd5);

        // Back-to-back two-flit packets.
        pop_cyc.delete();
        acc_cyc.delete();
        send(64'h4444_3333_2222_000A);
        send(64'h8888_7777_6666_000E);
        drain();
        chk("t4_count", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4) chk("t4_span", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);
        if (acc_cyc.size() == 2) chk("t4_accept_gap", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);

        // Reset while the third flit is on the link.
        send(64'h4444_3333_2222_001A);
        n = 0;
        while (!(link_v_o && link_data_o == 16'h3333) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_reach_3333", 64'(link_data_o), 64'h3333);
        reset_i = 1'b1;
        #1;
        chk("t5_link_v_drop", 64'(link_v_o), 64'd0);
        chk("t5_link_last_drop", 64'(link_last_o), 64'd0);
        chk("t5_ready_in_rst", 64'(ready_o), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        #1;
        chk("t5_ready_after", 64'(ready_o), 64'd1);
        pop_cyc.delete();
        send(64'h0000_0000_5555_0002);
        drain();
        chk("t5_count", 64'(pop_cyc.size()), 64'd1);

        // Random packets against random link backpressure.
        lr_mode = 1;
        for (int k = 0; k < 400; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send({$urandom, $urandom});
        end
        drain();
        lr_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
